// File: rtl/gen_burst_sequencer.sv
// Burst sequencer between the command side and the waveform generator: configures
// the generator, paces its active-low step enable and tracks returned FIFO writes.
module gen_burst_sequencer #(
    parameter int INT_BITS = 4,
    parameter int CNT_W    = 16,
    parameter int DIV_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [1:0]                 cmd_sel_i,
    input  logic signed [INT_BITS-1:0] cmd_amp_i,
    input  logic [CNT_W-1:0]           cmd_len_i,
    input  logic [DIV_W-1:0]           cmd_div_i,
    input  logic                       abort_i,
    input  logic                       fifo_full_i,
    input  logic                       gen_wr_en_i,
    output logic                       gen_en_low_o,
    output logic                       gen_enh_conf_o,
    output logic [1:0]                 gen_sel_o,
    output logic signed [INT_BITS-1:0] gen_amp_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       aborted_o,
    output logic                       err_o,
    output logic [CNT_W-1:0]           sample_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CONFIG   = 3'd1,
        S_SETTLE   = 3'd2,
        S_RUN      = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                     r_state;
    logic                       r_ready;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_aborted;
    logic                       r_conf;
    logic [1:0]                 r_sel;
    logic signed [INT_BITS-1:0] r_amp;
    logic [CNT_W-1:0]           r_len;
    logic [DIV_W-1:0]           r_div;
    logic [DIV_W-1:0]           r_div_cnt;
    logic [CNT_W-1:0]           r_issue_cnt;
    logic [CNT_W-1:0]           r_sample_cnt;
    logic                       r_err;

    logic                       w_accept;
    logic                       w_in_run;
    logic                       w_abort;
    logic                       w_tick;
    logic                       w_last_tick;
    logic                       w_strobe;
    logic                       w_cnt_inc;
    logic                       w_overrun;
    logic [CNT_W-1:0]           w_cnt_next;
    logic [CNT_W-1:0]           w_issue_next;

    assign w_accept     = cmd_valid_i && (r_state == S_IDLE);
    assign w_in_run     = (r_state == S_RUN);
    // Abort is only honoured mid-burst; IDLE has nothing to cancel and DONE wins.
    assign w_abort      = abort_i && (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_tick       = w_in_run && (r_div_cnt == {DIV_W{1'b0}}) && !fifo_full_i && !w_abort;
    assign w_issue_next = r_issue_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_last_tick  = w_tick && (w_issue_next == r_len);

    assign w_strobe     = gen_wr_en_i && !w_abort &&
                          ((r_state == S_RUN) || (r_state == S_WAIT_ACK));
    assign w_cnt_inc    = w_strobe && (r_sample_cnt < r_len);
    assign w_overrun    = w_strobe && (r_sample_cnt >= r_len);
    assign w_cnt_next   = w_cnt_inc ? (r_sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1}) : r_sample_cnt;

    // The step enable must follow FIFO full within the same cycle, so it is decoded, not registered.
    assign gen_en_low_o   = !w_tick;
    assign cmd_ready_o    = r_ready;
    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign aborted_o      = r_aborted;
    assign gen_enh_conf_o = r_conf;
    assign gen_sel_o      = r_sel;
    assign gen_amp_o      = r_amp;
    assign err_o          = r_err;
    assign sample_cnt_o   = r_sample_cnt;

    // Burst FSM; status outputs are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_conf    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_conf    <= 1'b0;
            if (w_abort) begin
                r_state   <= S_IDLE;
                r_ready   <= 1'b1;
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cmd_valid_i) begin
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                            if (cmd_len_i != {CNT_W{1'b0}}) begin
                                r_state <= S_CONFIG;
                                r_conf  <= 1'b1;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_CONFIG: begin
                        r_state <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        r_state <= S_RUN;
                    end
                    S_RUN: begin
                        if (w_last_tick) begin
                            r_state <= S_WAIT_ACK;
                        end
                    end
                    S_WAIT_ACK: begin
                        // Look at the post-strobe count so done lands in the cycle after the last write.
                        if (w_cnt_next == r_len) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Command latch, issue/divider pacing, returned-sample count and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel        <= 2'd0;
            r_amp        <= {INT_BITS{1'b0}};
            r_len        <= {CNT_W{1'b0}};
            r_div        <= {DIV_W{1'b0}};
            r_div_cnt    <= {DIV_W{1'b0}};
            r_issue_cnt  <= {CNT_W{1'b0}};
            r_sample_cnt <= {CNT_W{1'b0}};
            r_err        <= 1'b0;
        end else if (w_accept) begin
            r_sel        <= cmd_sel_i;
            r_amp        <= cmd_amp_i;
            r_len        <= cmd_len_i;
            r_div        <= cmd_div_i;
            r_div_cnt    <= {DIV_W{1'b0}};
            r_issue_cnt  <= {CNT_W{1'b0}};
            r_sample_cnt <= {CNT_W{1'b0}};
            r_err        <= 1'b0;
        end else begin
            r_sample_cnt <= w_cnt_next;
            if (w_overrun) begin
                r_err <= 1'b1;
            end
            if (w_tick) begin
                r_issue_cnt <= w_issue_next;
                r_div_cnt   <= r_div;
            end else if (w_in_run && !w_abort && (r_div_cnt != {DIV_W{1'b0}})) begin
                r_div_cnt <= r_div_cnt - {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_gen_burst_sequencer.sv
// Directed bench for gen_burst_sequencer: cycle-indexed stimulus with hand-derived expectations.
module tb_gen_burst_sequencer;

    logic              clk;
    logic              rst;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_sel_i;
    logic signed [3:0] cmd_amp_i;
    logic [15:0]       cmd_len_i;
    logic [7:0]        cmd_div_i;
    logic              abort_i;
    logic              fifo_full_i;
    logic              gen_wr_en_i;
    logic              gen_en_low_o;
    logic              gen_enh_conf_o;
    logic [1:0]        gen_sel_o;
    logic signed [3:0] gen_amp_o;
    logic              busy_o;
    logic              done_o;
    logic              aborted_o;
    logic              err_o;
    logic [15:0]       sample_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    gen_burst_sequencer #(.INT_BITS(4), .CNT_W(16), .DIV_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_sel_i      (cmd_sel_i),
        .cmd_amp_i      (cmd_amp_i),
        .cmd_len_i      (cmd_len_i),
        .cmd_div_i      (cmd_div_i),
        .abort_i        (abort_i),
        .fifo_full_i    (fifo_full_i),
        .gen_wr_en_i    (gen_wr_en_i),
        .gen_en_low_o   (gen_en_low_o),
        .gen_enh_conf_o (gen_enh_conf_o),
        .gen_sel_o      (gen_sel_o),
        .gen_amp_o      (gen_amp_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .aborted_o      (aborted_o),
        .err_o          (err_o),
        .sample_cnt_o   (sample_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enter the next cycle: inputs set after this return apply to that cycle's closing edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            fifo_full_i = 1'($urandom_range(0, 1));
            gen_wr_en_i = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 8; c++) begin
            cyc();
            rst = 1'b0;
            fifo_full_i = 1'($urandom_range(0, 1));
            gen_wr_en_i = 1'($urandom_range(0, 1));
            #2;
            n_vec++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready c=%0d got %b exp 1", c, cmd_ready_o); end
            n_vec++; if (gen_en_low_o !== 1'b1) begin n_err++; $display("FAIL reset_en_low c=%0d got %b exp 1", c, gen_en_low_o); end
            n_vec++; if (sample_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_cnt c=%0d got %0d exp 0", c, sample_cnt_o); end
            n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err c=%0d got %b exp 0", c, err_o); end
            n_vec++; if ({done_o, aborted_o, busy_o, gen_enh_conf_o} !== 4'b0000) begin n_err++; $display("FAIL reset_flags c=%0d got %b exp 0000", c, {done_o, aborted_o, busy_o, gen_enh_conf_o}); end
            n_vec++; if ({gen_sel_o, gen_amp_o} !== 6'd0) begin n_err++; $display("FAIL reset_selamp c=%0d got %b exp 0", c, {gen_sel_o, gen_amp_o}); end
        end
        fifo_full_i = 1'b0;
        gen_wr_en_i = 1'b0;
    endtask

    // sel=2 amp=3 len=4 div=0, generator echoes each step two cycles later.
    task automatic test_basic_burst();
        logic e_en_low, e_conf, e_done, e_ready, e_busy;
        for (int c = 0; c <= 11; c++) begin
            cyc();
            cmd_valid_i = (c == 0);
            cmd_sel_i = 2'd2; cmd_amp_i = 4'sd3; cmd_len_i = 16'd4; cmd_div_i = 8'd0;
            gen_wr_en_i = (c >= 5 && c <= 8);
            #2;
            e_en_low = !(c >= 3 && c <= 6);
            e_conf   = (c == 1);
            e_done   = (c == 9);
            e_ready  = (c == 0 || c >= 10);
            e_busy   = (c >= 1 && c <= 9);
            n_vec++; if (gen_en_low_o !== e_en_low) begin n_err++; $display("FAIL basic_en_low c=%0d got %b exp %b", c, gen_en_low_o, e_en_low); end
            n_vec++; if (gen_enh_conf_o !== e_conf) begin n_err++; $display("FAIL basic_conf c=%0d got %b exp %b", c, gen_enh_conf_o, e_conf); end
            n_vec++; if (done_o !== e_done) begin n_err++; $display("FAIL basic_done c=%0d got %b exp %b", c, done_o, e_done); end
            n_vec++; if (cmd_ready_o !== e_ready) begin n_err++; $display("FAIL basic_ready c=%0d got %b exp %b", c, cmd_ready_o, e_ready); end
            n_vec++; if (busy_o !== e_busy) begin n_err++; $display("FAIL basic_busy c=%0d got %b exp %b", c, busy_o, e_busy); end
            if (c == 1) begin
                n_vec++; if (gen_sel_o !== 2'd2) begin n_err++; $display("FAIL basic_sel got %0d exp 2", gen_sel_o); end
                n_vec++; if (gen_amp_o !== 4'sd3) begin n_err++; $display("FAIL basic_amp got %0d exp 3", gen_amp_o); end
            end
            if (c == 8) begin
                n_vec++; if (sample_cnt_o !== 16'd3) begin n_err++; $display("FAIL basic_cnt8 got %0d exp 3", sample_cnt_o); end
            end
            if (c == 9) begin
                n_vec++; if (sample_cnt_o !== 16'd4) begin n_err++; $display("FAIL basic_cnt9 got %0d exp 4", sample_cnt_o); end
                n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL basic_err got %b exp 0", err_o); end
            end
        end
        cmd_valid_i = 1'b0; gen_wr_en_i = 1'b0;
    endtask

    // len=3 div=2: steps at RUN cycles 0,3,6 (c=3,6,9), echoes one cycle later.
    task automatic test_rate_divider();
        logic e_en_low, e_done, e_ready;
        for (int c = 0; c <= 13; c++) begin
            cyc();
            cmd_valid_i = (c == 0);
            cmd_sel_i = 2'd0; cmd_amp_i = -4'sd2; cmd_len_i = 16'd3; cmd_div_i = 8'd2;
            gen_wr_en_i = (c == 4 || c == 7 || c == 10);
            #2;
            e_en_low = !(c == 3 || c == 6 || c == 9);
            e_done   = (c == 11);
            e_ready  = (c == 0 || c >= 12);
            n_vec++; if (gen_en_low_o !== e_en_low) begin n_err++; $display("FAIL div_en_low c=%0d got %b exp %b", c, gen_en_low_o, e_en_low); end
            n_vec++; if (done_o !== e_done) begin n_err++; $display("FAIL div_done c=%0d got %b exp %b", c, done_o, e_done); end
            n_vec++; if (cmd_ready_o !== e_ready) begin n_err++; $display("FAIL div_ready c=%0d got %b exp %b", c, cmd_ready_o, e_ready); end
            if (c == 1) begin
                n_vec++; if (gen_amp_o !== -4'sd2) begin n_err++; $display("FAIL div_amp got %0d exp -2", gen_amp_o); end
            end
            if (c == 8) begin
                n_vec++; if (sample_cnt_o !== 16'd2) begin n_err++; $display("FAIL div_cnt8 got %0d exp 2", sample_cnt_o); end
            end
            if (c == 11) begin
                n_vec++; if (sample_cnt_o !== 16'd3) begin n_err++; $display("FAIL div_cnt11 got %0d exp 3", sample_cnt_o); end
            end
        end
        cmd_valid_i = 1'b0; gen_wr_en_i = 1'b0;
    endtask

    // len=4 div=0 with FIFO full over RUN cycles 1-3: steps at c=3,7,8,9.
    task automatic test_fifo_stall();
        logic e_en_low, e_done, e_ready;
        for (int c = 0; c <= 13; c++) begin
            cyc();
            cmd_valid_i = (c == 0);
            cmd_sel_i = 2'd1; cmd_amp_i = 4'sd7; cmd_len_i = 16'd4; cmd_div_i = 8'd0;
            fifo_full_i = (c >= 4 && c <= 6);
            gen_wr_en_i = (c == 4 || c == 8 || c == 9 || c == 10);
            #2;
            e_en_low = !(c == 3 || c == 7 || c == 8 || c == 9);
            e_done   = (c == 11);
            e_ready  = (c == 0 || c >= 12);
            n_vec++; if (gen_en_low_o !== e_en_low) begin n_err++; $display("FAIL stall_en_low c=%0d got %b exp %b", c, gen_en_low_o, e_en_low); end
            n_vec++; if (done_o !== e_done) begin n_err++; $display("FAIL stall_done c=%0d got %b exp %b", c, done_o, e_done); end
            n_vec++; if (cmd_ready_o !== e_ready) begin n_err++; $display("FAIL stall_ready c=%0d got %b exp %b", c, cmd_ready_o, e_ready); end
        end
        cmd_valid_i = 1'b0; gen_wr_en_i = 1'b0; fifo_full_i = 1'b0;
    endtask

    task automatic test_zero_length();
        logic e_done, e_ready;
        for (int c = 0; c <= 3; c++) begin
            cyc();
            cmd_valid_i = (c == 0);
            cmd_sel_i = 2'd1; cmd_amp_i = 4'sd5; cmd_len_i = 16'd0; cmd_div_i = 8'd3;
            #2;
            e_done  = (c == 1);
            e_ready = (c != 1);
            n_vec++; if (gen_enh_conf_o !== 1'b0) begin n_err++; $display("FAIL zero_conf c=%0d got %b exp 0", c, gen_enh_conf_o); end
            n_vec++; if (done_o !== e_done) begin n_err++; $display("FAIL zero_done c=%0d got %b exp %b", c, done_o, e_done); end
            n_vec++; if (cmd_ready_o !== e_ready) begin n_err++; $display("FAIL zero_ready c=%0d got %b exp %b", c, cmd_ready_o, e_ready); end
            n_vec++; if (gen_en_low_o !== 1'b1) begin n_err++; $display("FAIL zero_en_low c=%0d got %b exp 1", c, gen_en_low_o); end
            if (c >= 1) begin
                n_vec++; if (sample_cnt_o !== 16'd0) begin n_err++; $display("FAIL zero_cnt c=%0d got %0d exp 0", c, sample_cnt_o); end
            end
        end
        cmd_valid_i = 1'b0;
    endtask

    // len=5 aborted after two steps; abort again while IDLE is ignored; a len=1 burst follows.
    task automatic test_abort();
        logic e_en_low, e_abort, e_done, e_ready, e_busy;
        for (int c = 0; c <= 13; c++) begin
            cyc();
            cmd_valid_i = (c == 0 || c == 7);
            cmd_sel_i = (c == 7) ? 2'd1 : 2'd3;
            cmd_amp_i = (c == 7) ? 4'sd2 : 4'sd1;
            cmd_len_i = (c == 7) ? 16'd1 : 16'd5;
            cmd_div_i = 8'd0;
            abort_i = (c == 5 || c == 7);
            gen_wr_en_i = (c == 3 || c == 4 || c == 6 || c == 11);
            #2;
            e_en_low = !(c == 3 || c == 4 || c == 10);
            e_abort  = (c == 6);
            e_done   = (c == 12);
            e_ready  = (c == 0 || c == 6 || c == 7 || c == 13);
            e_busy   = ((c >= 1 && c <= 5) || (c >= 8 && c <= 12));
            n_vec++; if (gen_en_low_o !== e_en_low) begin n_err++; $display("FAIL abort_en_low c=%0d got %b exp %b", c, gen_en_low_o, e_en_low); end
            n_vec++; if (aborted_o !== e_abort) begin n_err++; $display("FAIL abort_pulse c=%0d got %b exp %b", c, aborted_o, e_abort); end
            n_vec++; if (done_o !== e_done) begin n_err++; $display("FAIL abort_done c=%0d got %b exp %b", c, done_o, e_done); end
            n_vec++; if (cmd_ready_o !== e_ready) begin n_err++; $display("FAIL abort_ready c=%0d got %b exp %b", c, cmd_ready_o, e_ready); end
            n_vec++; if (busy_o !== e_busy) begin n_err++; $display("FAIL abort_busy c=%0d got %b exp %b", c, busy_o, e_busy); end
            if (c >= 5 && c <= 7) begin
                n_vec++; if (sample_cnt_o !== 16'd2) begin n_err++; $display("FAIL abort_cnt_hold c=%0d got %0d exp 2", c, sample_cnt_o); end
            end
            if (c == 8) begin
                n_vec++; if (sample_cnt_o !== 16'd0) begin n_err++; $display("FAIL abort_cnt_clr got %0d exp 0", sample_cnt_o); end
                n_vec++; if (gen_enh_conf_o !== 1'b1 || gen_sel_o !== 2'd1) begin n_err++; $display("FAIL abort_reconf got conf=%b sel=%0d exp conf=1 sel=1", gen_enh_conf_o, gen_sel_o); end
            end
            if (c == 12) begin
                n_vec++; if (sample_cnt_o !== 16'd1) begin n_err++; $display("FAIL abort_cnt_end got %0d exp 1", sample_cnt_o); end
            end
        end
        cmd_valid_i = 1'b0; abort_i = 1'b0; gen_wr_en_i = 1'b0;
    endtask

    // len=2 div=3 with a third strobe in RUN: overrun is sticky until the next accept (len=0 at c=11).
    task automatic test_overrun();
        logic e_en_low, e_err, e_done, e_ready;
        for (int c = 0; c <= 13; c++) begin
            cyc();
            cmd_valid_i = (c == 0 || c == 11);
            cmd_sel_i = 2'd0; cmd_amp_i = 4'sd7;
            cmd_len_i = (c == 11) ? 16'd0 : 16'd2;
            cmd_div_i = 8'd3;
            gen_wr_en_i = (c == 3 || c == 4 || c == 5 || c == 10);
            #2;
            e_en_low = !(c == 3 || c == 7);
            e_err    = (c >= 6 && c <= 11);
            e_done   = (c == 9 || c == 12);
            e_ready  = (c == 0 || c == 10 || c == 11 || c == 13);
            n_vec++; if (gen_en_low_o !== e_en_low) begin n_err++; $display("FAIL ovr_en_low c=%0d got %b exp %b", c, gen_en_low_o, e_en_low); end
            n_vec++; if (err_o !== e_err) begin n_err++; $display("FAIL ovr_err c=%0d got %b exp %b", c, err_o, e_err); end
            n_vec++; if (done_o !== e_done) begin n_err++; $display("FAIL ovr_done c=%0d got %b exp %b", c, done_o, e_done); end
            n_vec++; if (cmd_ready_o !== e_ready) begin n_err++; $display("FAIL ovr_ready c=%0d got %b exp %b", c, cmd_ready_o, e_ready); end
            if (c >= 5 && c <= 11) begin
                n_vec++; if (sample_cnt_o !== 16'd2) begin n_err++; $display("FAIL ovr_cnt c=%0d got %0d exp 2", c, sample_cnt_o); end
            end
        end
        cmd_valid_i = 1'b0; gen_wr_en_i = 1'b0;
    endtask

    // Reset asserted in RUN discards the burst without done or aborted.
    task automatic test_reset_mid_burst();
        for (int c = 0; c <= 8; c++) begin
            cyc();
            cmd_valid_i = (c == 0);
            cmd_sel_i = 2'd2; cmd_amp_i = 4'sd3; cmd_len_i = 16'd4; cmd_div_i = 8'd0;
            rst = (c == 4);
            gen_wr_en_i = (c == 4 || c == 6);
            #2;
            if (c == 4) begin
                n_vec++; if (gen_en_low_o !== 1'b0) begin n_err++; $display("FAIL rstmid_step got %b exp 0", gen_en_low_o); end
            end
            if (c >= 5) begin
                n_vec++; if ({done_o, aborted_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL rstmid_flags c=%0d got %b exp 000", c, {done_o, aborted_o, busy_o}); end
                n_vec++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_ready c=%0d got %b exp 1", c, cmd_ready_o); end
                n_vec++; if (sample_cnt_o !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt c=%0d got %0d exp 0", c, sample_cnt_o); end
                n_vec++; if (gen_en_low_o !== 1'b1) begin n_err++; $display("FAIL rstmid_en_low c=%0d got %b exp 1", c, gen_en_low_o); end
                n_vec++; if ({gen_sel_o, gen_amp_o} !== 6'd0) begin n_err++; $display("FAIL rstmid_selamp c=%0d got %b exp 0", c, {gen_sel_o, gen_amp_o}); end
            end
        end
        cmd_valid_i = 1'b0; rst = 1'b0; gen_wr_en_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_sel_i = 2'd0;
        cmd_amp_i = 4'sd0;
        cmd_len_i = 16'd0;
        cmd_div_i = 8'd0;
        abort_i = 1'b0;
        fifo_full_i = 1'b0;
        gen_wr_en_i = 1'b0;
        test_reset();
        test_basic_burst();
        test_rate_divider();
        test_fifo_stall();
        test_zero_length();
        test_abort();
        test_overrun();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gen_burst_sequencer.md
Name: gen_burst_sequencer

Overview:
- Control block between the host/command side and the waveform generator feeding the FIFO.
- Accepts a burst command (waveform select, amplitude, sample count, rate divider) and drives the generator's config strobe to load amplitude and select.
- Paces the generator's active-low step enable at the programmed rate and stalls on FIFO full.
- Counts the generator's FIFO write strobes and reports completion, abort or an overrun error.

Parameters:
- INT_BITS, 4, width of the amplitude integer field passed to the generator
- CNT_W, 16, width of the burst length and sample counters
- DIV_W, 8, width of the rate divider (a step is issued every div+1 cycles)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_sel_i  in  2  waveform select: 0 sin, 1 cos, 2 triangle, 3 square
- cmd_amp_i  in  INT_BITS  signed amplitude
- cmd_len_i  in  CNT_W  samples in the burst
- cmd_div_i  in  DIV_W  rate divider
- abort_i  in  1  cancel the active burst
- fifo_full_i  in  1  FIFO full; blocks step issue
- gen_wr_en_i  in  1  generator sample write strobe (its wr_en_o)
- gen_en_low_o  out  1  generator step enable, active-low
- gen_enh_conf_o  out  1  generator config strobe
- gen_sel_o  out  2  select to generator
- gen_amp_o  out  INT_BITS  amplitude to generator
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle completion pulse
- aborted_o  out  1  one-cycle abort pulse
- err_o  out  1  sticky overrun flag
- sample_cnt_o  out  CNT_W  write strobes received in the current burst

Behaviour:
- Reset (rst=1 at a clk edge):
  - state IDLE; gen_en_low_o=1, gen_enh_conf_o=0, gen_sel_o=0, gen_amp_o=0.
  - busy_o=0, done_o=0, aborted_o=0, err_o=0, sample_cnt_o=0.
  - Internal issue counter and divider counter cleared; cmd_ready_o=1 from the first cycle after reset.
  - Reset mid-burst discards the burst; no done or aborted pulse.
- cmd_ready_o = (state==IDLE). Outside IDLE, cmd_valid_i is ignored.
- States: IDLE, CONFIG, SETTLE, RUN, WAIT_ACK, DONE.
- IDLE:
  - On accept: latch sel, amp, len, div; clear sample_cnt_o, issue counter, divider counter and err_o.
  - len!=0 goes to CONFIG; len==0 goes to DONE with no config strobe.
- CONFIG (1 cycle): gen_enh_conf_o=1; gen_sel_o/gen_amp_o carry the latched values and hold them until the next accept. Goes to SETTLE.
- SETTLE (1 cycle): gen_enh_conf_o=0, gen_en_low_o=1. Goes to RUN.
- RUN:
  - tick = (div_cnt==0) && !fifo_full_i.
  - gen_en_low_o = !tick, decoded combinationally in the same cycle.
  - On tick: issue_cnt+1 and div_cnt reloads to div.
  - If div_cnt!=0: div_cnt decrements.
  - If div_cnt==0 and FIFO is full: hold (stall).
  - div_cnt is 0 on RUN entry, so the first step is issued in the first RUN cycle.
  - div=0 gives one step per cycle.
  - After the tick that makes issue_cnt==len, go to WAIT_ACK.
- WAIT_ACK: gen_en_low_o=1; go to DONE when sample_cnt_o==len.
- DONE (1 cycle): done_o=1, busy_o=1. Goes to IDLE.
- busy_o=1 in CONFIG, SETTLE, RUN, WAIT_ACK and DONE.
- sample_cnt_o:
  - Increments on gen_wr_en_i only while in RUN or WAIT_ACK and sample_cnt_o<len.
  - A strobe arriving when sample_cnt_o==len sets err_o and does not increment.
  - Strobes in IDLE, CONFIG, SETTLE or DONE are ignored (no count, no error).
  - A strobe in the same cycle as the final tick counts normally.
- abort_i in any non-IDLE state except DONE:
  - Next state IDLE; aborted_o=1 for one cycle.
  - gen_en_low_o=1 in the abort cycle; any tick in that cycle is suppressed.
  - sample_cnt_o is held; no done_o.
- abort_i in IDLE or DONE is ignored; done_o has priority.
- Counters do not wrap: issue_cnt stops at len, sample_cnt_o saturates at len.

Test Plan:
- Reset, then idle with random fifo_full_i/gen_wr_en_i → cmd_ready_o=1, gen_en_low_o=1, sample_cnt_o=0, err_o=0, no pulses.
- Accept at cycle T: sel=2, amp=3, len=4, div=0, fifo not full, generator echoes wr_en 2 cycles after each step → gen_enh_conf_o=1 at T+1 with gen_sel_o=2, gen_amp_o=3; gen_en_low_o=0 at T+3..T+6; sample_cnt_o reaches 4 at T+9; done_o at T+9; cmd_ready_o=1 at T+10.
- len=3, div=2 → steps at RUN cycles 0, 3, 6 only; done_o once after the 3rd strobe.
- len=4, div=0, fifo_full_i=1 for RUN cycles 1–3 → steps in cycles 0, 4, 5, 6; no step while full.
- len=0 → no gen_enh_conf_o; done_o in the cycle after accept; sample_cnt_o=0.
- abort_i after 2 of 5 steps → aborted_o pulse, IDLE next cycle, gen_en_low_o=1, sample_cnt_o holds its value, later strobes ignored; new command accepted the next cycle.
- len=2 with an extra 3rd strobe in WAIT_ACK/RUN → sample_cnt_o=2, err_o=1 sticky until the next accept.
